// File: rtl/matrix_alu_pkg.sv
// Shared definitions for the matrix ALU row datapath.
// Holds the opcode encodings, a lane-extract helper and the saturation limits.
// Elements up to MAX_ELEM_W bits and rows up to MAX_ROW_W bits are supported.
package matrix_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam int MAX_ELEM_W = 64;
    localparam int MAX_ROW_W  = 2048;

    // Returns lane 'lane' of a packed row whose elements are 'width' bits wide.
    // The element sits right-justified in the result; the caller truncates it.
    function automatic logic [MAX_ELEM_W-1:0] lane_extract(
        input logic [MAX_ROW_W-1:0] row,
        input int                   lane,
        input int                   width
    );
        logic [MAX_ROW_W-1:0]  shifted;
        logic [MAX_ELEM_W-1:0] mask;
        shifted = row >> (lane * width);
        if (width >= MAX_ELEM_W) begin
            mask = '1;
        end else begin
            mask = (MAX_ELEM_W'(1) << width) - MAX_ELEM_W'(1);
        end
        return shifted[MAX_ELEM_W-1:0] & mask;
    endfunction

    // Largest positive two's-complement value of a 'width'-bit element.
    function automatic logic [MAX_ELEM_W-1:0] sat_max(input int width);
        return (MAX_ELEM_W'(1) << (width - 1)) - MAX_ELEM_W'(1);
    endfunction

    // Most negative two's-complement value of a 'width'-bit element
    // (right-justified; truncating to 'width' bits gives 100..0).
    function automatic logic [MAX_ELEM_W-1:0] sat_min(input int width);
        return MAX_ELEM_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/addsub_lane.sv
// Single-lane signed add/subtract with overflow detect and optional saturation.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: a, b operands; sub selects a-b; result is the lane value; overflow flags signed overflow.
module addsub_lane
    import matrix_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SATURATE   = 1
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sub,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow
);

    localparam logic [DATA_WIDTH-1:0] MAX_VAL = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = DATA_WIDTH'(sat_min(DATA_WIDTH));

    logic [DATA_WIDTH:0] a_ext;
    logic [DATA_WIDTH:0] b_ext;
    logic [DATA_WIDTH:0] wide;

    always_comb begin
        a_ext    = {a[DATA_WIDTH-1], a};
        b_ext    = {b[DATA_WIDTH-1], b};
        wide     = sub ? (a_ext - b_ext) : (a_ext + b_ext);
        // The extra bit holds the true sign; disagreement with the element
        // sign bit is exactly the same-sign/different-sign overflow rule.
        overflow = wide[DATA_WIDTH] ^ wide[DATA_WIDTH-1];
        result   = wide[DATA_WIDTH-1:0];
        if ((SATURATE != 0) && overflow) begin
            result = wide[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/row_addsub_unit.sv
// Row-wise element add/subtract engine: S1 registers operands, S2 computes and registers the row.
// Latency: beat accepted at edge N is registered in S2 (OutValid) at edge N+1 and consumed from edge N+2.
// Backpressure: OutReady low holds S2; S1 holds when full and Ready drops. Illegal opcodes are swallowed.
// Ports: Clock/ClearAll (sync, active-high); Enable/Ready input handshake with Operation, RowA, RowB;
// OutValid/OutReady output handshake with NewRow, OverflowLanes; Done, sticky Error/ErrorClear, ResultCount.
module row_addsub_unit
    import matrix_alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int LANES       = 4,
    parameter int SATURATE    = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                        Clock,
    input  logic                        ClearAll,
    input  logic                        Enable,
    output logic                        Ready,
    input  logic [2:0]                  Operation,
    input  logic [LANES*DATA_WIDTH-1:0] RowA,
    input  logic [LANES*DATA_WIDTH-1:0] RowB,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [LANES*DATA_WIDTH-1:0] NewRow,
    output logic [LANES-1:0]            OverflowLanes,
    output logic                        Done,
    output logic                        Error,
    input  logic                        ErrorClear,
    output logic [COUNT_WIDTH-1:0]      ResultCount
);

    localparam int ROW_W = LANES * DATA_WIDTH;

    // Held low through reset so Ready only rises on the first edge after release.
    logic             started;

    logic             s1_valid;
    logic [ROW_W-1:0] s1_a;
    logic [ROW_W-1:0] s1_b;
    logic [2:0]       s1_op;

    logic             s2_adv;
    logic             accept;
    logic             s1_legal;
    logic             s1_leave;
    logic [ROW_W-1:0] lane_res;
    logic [LANES-1:0] lane_ovf;

    assign s2_adv   = !OutValid || OutReady;
    assign Ready    = started && (!s1_valid || s2_adv);
    assign accept   = Enable && Ready;
    assign s1_legal = (s1_op == OP_ADD) || (s1_op == OP_SUB);
    assign s1_leave = s1_valid && s2_adv;
    assign Done     = OutValid && OutReady;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        addsub_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .SATURATE   (SATURATE)
        ) u_lane (
            .a        (DATA_WIDTH'(lane_extract(MAX_ROW_W'(s1_a), i, DATA_WIDTH))),
            .b        (DATA_WIDTH'(lane_extract(MAX_ROW_W'(s1_b), i, DATA_WIDTH))),
            .sub      (s1_op == OP_SUB),
            .result   (lane_res[i*DATA_WIDTH +: DATA_WIDTH]),
            .overflow (lane_ovf[i])
        );
    end

    always_ff @(posedge Clock) begin
        if (ClearAll) begin
            started       <= 1'b0;
            s1_valid      <= 1'b0;
            s1_a          <= '0;
            s1_b          <= '0;
            s1_op         <= '0;
            OutValid      <= 1'b0;
            NewRow        <= '0;
            OverflowLanes <= '0;
            Error         <= 1'b0;
            ResultCount   <= '0;
        end else begin
            started <= 1'b1;

            // S1: a new beat may enter in the same cycle the old one leaves.
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= RowA;
                s1_b     <= RowB;
                s1_op    <= Operation;
            end else if (s1_leave) begin
                s1_valid <= 1'b0;
            end

            // S2: an illegal beat leaves S1 but leaves a bubble here.
            if (s2_adv) begin
                OutValid <= s1_valid && s1_legal;
                if (s1_valid && s1_legal) begin
                    NewRow        <= lane_res;
                    OverflowLanes <= lane_ovf;
                end
            end

            // Set has priority over clear.
            if (s1_leave && (!s1_legal || (|lane_ovf))) begin
                Error <= 1'b1;
            end else if (ErrorClear) begin
                Error <= 1'b0;
            end

            if (Done) begin
                ResultCount <= ResultCount + COUNT_WIDTH'(1);
            end
        end
    end

endmodule
